line_follow_ctrl_v2: RTL and testbench

- Parametrised successor to the LFA line-following motor controller.
- Accepts NUM_SENSORS ADC readings and classifies each one with hysteresis.
- Runs an explicit IDLE/FOLLOW/NODE/TURN/LOST/STOP state machine and drives the two H-bridge direction pairs plus duty words for the PWM block.
- Adds debounced node detection, turns that terminate on line reacquisition or timeout, a node counter, and aligned direction/duty outputs.

---
 rtl/line_follow_pkg.sv | 50 +++++
 rtl/lfa_classifier.sv | 44 ++++
 rtl/line_follow_ctrl_v2.sv | 258 +++++++++++++++++++++++++
 tb/tb_line_follow_ctrl_v2.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/line_follow_pkg.sv
// Shared types and drive patterns for the line-following motor controller.
// Used by line_follow_ctrl_v2 (optional LOST state via LINE_FOLLOW_LOST_RECOVERY_EN).
package line_follow_pkg;

  localparam int unsigned PAT_DUTY_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FOLLOW = 3'd1,
    ST_NODE   = 3'd2,
    ST_TURN   = 3'd3,
    ST_LOST   = 3'd4,
    ST_STOP   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    TURN_STRAIGHT = 2'd0,
    TURN_RIGHT    = 2'd1,
    TURN_UTURN    = 2'd2,
    TURN_LEFT     = 2'd3
  } turn_t;

  // H-bridge direction pins plus left/right duty words, applied together.
  typedef struct packed {
    logic                  m1_a;
    logic                  m1_b;
    logic                  m2_a;
    logic                  m2_b;
    logic [PAT_DUTY_W-1:0] dc1;
    logic [PAT_DUTY_W-1:0] dc2;
  } drive_t;

  localparam drive_t DRV_FWD     = '{m1_a: 1'b1, m1_b: 1'b0, m2_a: 1'b1, m2_b: 1'b0, dc1: 5'd16, dc2: 5'd20};
  localparam drive_t DRV_STEER_R = '{m1_a: 1'b1, m1_b: 1'b0, m2_a: 1'b0, m2_b: 1'b1, dc1: 5'd20, dc2: 5'd10};
  localparam drive_t DRV_STEER_L = '{m1_a: 1'b0, m1_b: 1'b1, m2_a: 1'b1, m2_b: 1'b0, dc1: 5'd10, dc2: 5'd24};
  localparam drive_t DRV_T_RIGHT = '{m1_a: 1'b1, m1_b: 1'b0, m2_a: 1'b0, m2_b: 1'b1, dc1: 5'd18, dc2: 5'd5};
  localparam drive_t DRV_T_UTURN = '{m1_a: 1'b1, m1_b: 1'b0, m2_a: 1'b0, m2_b: 1'b1, dc1: 5'd10, dc2: 5'd28};
  localparam drive_t DRV_T_LEFT  = '{m1_a: 1'b0, m1_b: 1'b1, m2_a: 1'b1, m2_b: 1'b0, dc1: 5'd3,  dc2: 5'd24};
  localparam drive_t DRV_HALT    = '{m1_a: 1'b0, m1_b: 1'b0, m2_a: 1'b0, m2_b: 1'b0, dc1: 5'd0,  dc2: 5'd0};

  function automatic drive_t turn_drive(input turn_t t);
    case (t)
      TURN_RIGHT: return DRV_T_RIGHT;
      TURN_UTURN: return DRV_T_UTURN;
      TURN_LEFT:  return DRV_T_LEFT;
      default:    return DRV_FWD;
    endcase
  endfunction

endpackage

// File: rtl/lfa_classifier.sv
// Per-channel black/white classification with hysteresis between LO_TH and HI_TH.
// Classes are combinational from the current reading so the controller reacts in one cycle.
module lfa_classifier #(
  parameter int unsigned NUM_SENSORS = 3,
  parameter int unsigned ADC_W       = 12,
  parameter int unsigned HI_TH       = 1000,
  parameter int unsigned LO_TH       = 200
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_SENSORS*ADC_W-1:0] sensors_i,
  output logic [NUM_SENSORS-1:0]       black_c,
  output logic                         all_black_c,
  output logic                         all_white_c
);

  logic [NUM_SENSORS-1:0] class_q;
  logic [NUM_SENSORS-1:0] class_d;

  // Readings inside the dead band keep the previous class.
  always_comb begin
    class_d = class_q;
    for (int unsigned i = 0; i < NUM_SENSORS; i++) begin
      if (sensors_i[i*ADC_W +: ADC_W] > ADC_W'(HI_TH)) begin
        class_d[i] = 1'b1;
      end else if (sensors_i[i*ADC_W +: ADC_W] < ADC_W'(LO_TH)) begin
        class_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      class_q <= '0;
    end else begin
      class_q <= class_d;
    end
  end

  assign black_c     = class_d;
  assign all_black_c = &class_d;
  assign all_white_c = ~|class_d;

endmodule

// File: rtl/line_follow_ctrl_v2.sv
// Line-following motor controller: IDLE/FOLLOW/NODE/TURN/STOP FSM with registered drive outputs.
// Define LINE_FOLLOW_LOST_RECOVERY_EN to add the LOST state that pivots back onto the line.
module line_follow_ctrl_v2
  import line_follow_pkg::*;
#(
  parameter int unsigned NUM_SENSORS   = 3,
  parameter int unsigned ADC_W         = 12,
  parameter int unsigned HI_TH         = 1000,
  parameter int unsigned LO_TH         = 200,
  parameter int unsigned DUTY_W        = 5,
  parameter int unsigned NODE_DEBOUNCE = 8,
  parameter int unsigned TURN_MIN      = 3125,
  parameter int unsigned TURN_MAX      = 62500,
  parameter int unsigned LOST_CYCLES   = 1563
) (
  input  logic                         clk_3125KHz,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         end_path,
  input  logic [NUM_SENSORS*ADC_W-1:0] sensors,
  input  logic [1:0]                   turn_flag,
  output logic                         m1_a,
  output logic                         m1_b,
  output logic                         m2_a,
  output logic                         m2_b,
  output logic [DUTY_W-1:0]            dc1,
  output logic [DUTY_W-1:0]            dc2,
  output logic                         node_flag,
  output logic                         node_changed,
  output logic [7:0]                   node_count,
  output logic                         turn_timeout,
  output logic [2:0]                   state_o
);

  localparam int unsigned C      = (NUM_SENSORS - 1) / 2;
  localparam int unsigned DEB_W  = $clog2(NODE_DEBOUNCE + 1);
  localparam int unsigned TURN_W = $clog2(TURN_MAX + 1);

  logic [NUM_SENSORS-1:0] black_c;
  logic                   all_black_c;
  logic                   all_white_c;

  lfa_classifier #(
    .NUM_SENSORS (NUM_SENSORS),
    .ADC_W       (ADC_W),
    .HI_TH       (HI_TH),
    .LO_TH       (LO_TH)
  ) u_classifier (
    .clk         (clk_3125KHz),
    .rst         (rst),
    .sensors_i   (sensors),
    .black_c     (black_c),
    .all_black_c (all_black_c),
    .all_white_c (all_white_c)
  );

  state_t              state_q, state_d;
  drive_t              drv_q, drv_d;
  logic [DEB_W-1:0]    deb_q, deb_d, deb_inc;
  logic [TURN_W-1:0]   turn_cnt_q, turn_cnt_d, turn_cnt_inc;
  turn_t               turn_reg_q, turn_reg_d;
  logic [7:0]          node_count_q, node_count_d;
  logic                node_flag_q, node_flag_d;
  logic                node_changed_q, node_changed_d;
  logic                turn_timeout_q, turn_timeout_d;

  logic                right_any, left_any, only_r, only_l, reacq;
  logic                turn_ok, turn_expired;
  drive_t              follow_drv;

`ifdef LINE_FOLLOW_LOST_RECOVERY_EN
  localparam int unsigned LOST_W = $clog2(LOST_CYCLES + 1);
  logic [LOST_W-1:0]   lost_cnt_q, lost_cnt_d;
  logic                last_right_q, last_right_d;
  drive_t              lost_drv;
`endif

  // Which side of the centre channel currently sees the line.
  always_comb begin
    right_any = 1'b0;
    left_any  = 1'b0;
    for (int unsigned i = 0; i < NUM_SENSORS; i++) begin
      if (i > C) right_any = right_any | black_c[i];
      if (i < C) left_any  = left_any  | black_c[i];
    end
  end

  assign only_r = right_any & ~left_any & ~black_c[C];
  assign only_l = left_any & ~right_any & ~black_c[C];
  assign reacq  = black_c[C] & ~black_c[0] & ~black_c[NUM_SENSORS-1];

  always_comb begin
    follow_drv = DRV_FWD;
    if (all_white_c)  follow_drv = DRV_FWD;
    else if (only_r)  follow_drv = DRV_STEER_R;
    else if (only_l)  follow_drv = DRV_STEER_L;
  end

  assign deb_inc      = (&deb_q) ? deb_q : deb_q + DEB_W'(1);
  assign turn_cnt_inc = (&turn_cnt_q) ? turn_cnt_q : turn_cnt_q + TURN_W'(1);
  assign turn_ok      = (turn_cnt_q >= TURN_W'(TURN_MIN)) && reacq;
  assign turn_expired = turn_cnt_q >= TURN_W'(TURN_MAX);

`ifdef LINE_FOLLOW_LOST_RECOVERY_EN
  assign lost_drv = last_right_q ? DRV_STEER_R : DRV_STEER_L;

  always_comb begin
    last_right_d = last_right_q;
    if (right_any && !left_any)      last_right_d = 1'b1;
    else if (left_any && !right_any) last_right_d = 1'b0;
  end
`endif

  // Next-state and next-output logic; end_path overrides every transition.
  always_comb begin
    state_d        = state_q;
    drv_d          = drv_q;
    deb_d          = deb_q;
    turn_cnt_d     = turn_cnt_q;
    turn_reg_d     = turn_reg_q;
    node_count_d   = node_count_q;
    node_changed_d = 1'b0;
    turn_timeout_d = 1'b0;
`ifdef LINE_FOLLOW_LOST_RECOVERY_EN
    lost_cnt_d     = '0;
`endif

    if (end_path) begin
      state_d = ST_STOP;
      drv_d   = DRV_HALT;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          drv_d = DRV_HALT;
          if (start) begin
            state_d = ST_FOLLOW;
            drv_d   = follow_drv;
          end
        end

        ST_FOLLOW: begin
          drv_d = follow_drv;
          if (all_black_c) begin
            state_d = ST_NODE;
            deb_d   = DEB_W'(1);
            drv_d   = drv_q;
          end
`ifdef LINE_FOLLOW_LOST_RECOVERY_EN
          else if (all_white_c) begin
            if (lost_cnt_q >= LOST_W'(LOST_CYCLES - 1)) begin
              state_d = ST_LOST;
              drv_d   = lost_drv;
            end else begin
              lost_cnt_d = lost_cnt_q + LOST_W'(1);
            end
          end
`endif
        end

        // Drive holds the last FOLLOW pattern while the node is debounced.
        ST_NODE: begin
          if (!all_black_c) begin
            state_d = ST_FOLLOW;
            deb_d   = '0;
            drv_d   = follow_drv;
          end else if (deb_inc >= DEB_W'(NODE_DEBOUNCE)) begin
            state_d    = ST_TURN;
            deb_d      = '0;
            turn_reg_d = turn_t'(turn_flag);
            turn_cnt_d = '0;
            drv_d      = turn_drive(turn_t'(turn_flag));
          end else begin
            deb_d = deb_inc;
          end
        end

        ST_TURN: begin
          drv_d      = turn_drive(turn_reg_q);
          turn_cnt_d = turn_cnt_inc;
          if (turn_ok || turn_expired) begin
            state_d        = ST_FOLLOW;
            drv_d          = follow_drv;
            turn_cnt_d     = '0;
            node_changed_d = 1'b1;
            turn_timeout_d = ~turn_ok;
            node_count_d   = node_count_q + 8'd1;
          end
        end

`ifdef LINE_FOLLOW_LOST_RECOVERY_EN
        ST_LOST: begin
          drv_d = lost_drv;
          if (!all_white_c) begin
            state_d = ST_FOLLOW;
            drv_d   = follow_drv;
          end
        end
`endif

        ST_STOP: begin
          drv_d = DRV_HALT;
        end

        default: begin
          state_d = ST_IDLE;
          drv_d   = DRV_HALT;
        end
      endcase
    end
  end

  assign node_flag_d = (state_d == ST_NODE) || (state_d == ST_TURN);

  always_ff @(posedge clk_3125KHz) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      drv_q          <= DRV_HALT;
      deb_q          <= '0;
      turn_cnt_q     <= '0;
      turn_reg_q     <= TURN_STRAIGHT;
      node_count_q   <= '0;
      node_flag_q    <= 1'b0;
      node_changed_q <= 1'b0;
      turn_timeout_q <= 1'b0;
`ifdef LINE_FOLLOW_LOST_RECOVERY_EN
      lost_cnt_q     <= '0;
      last_right_q   <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      drv_q          <= drv_d;
      deb_q          <= deb_d;
      turn_cnt_q     <= turn_cnt_d;
      turn_reg_q     <= turn_reg_d;
      node_count_q   <= node_count_d;
      node_flag_q    <= node_flag_d;
      node_changed_q <= node_changed_d;
      turn_timeout_q <= turn_timeout_d;
`ifdef LINE_FOLLOW_LOST_RECOVERY_EN
      lost_cnt_q     <= lost_cnt_d;
      last_right_q   <= last_right_d;
`endif
    end
  end

  assign m1_a         = drv_q.m1_a;
  assign m1_b         = drv_q.m1_b;
  assign m2_a         = drv_q.m2_a;
  assign m2_b         = drv_q.m2_b;
  assign dc1          = DUTY_W'(drv_q.dc1);
  assign dc2          = DUTY_W'(drv_q.dc2);
  assign node_flag    = node_flag_q;
  assign node_changed = node_changed_q;
  assign node_count   = node_count_q;
  assign turn_timeout = turn_timeout_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_line_follow_ctrl_v2.sv
// Self-checking bench for line_follow_ctrl_v2 (default build, shortened turn timing).
module tb_line_follow_ctrl_v2;

  localparam int unsigned NS   = 3;
  localparam int unsigned AW   = 12;
  localparam int unsigned TMIN = 40;
  localparam int unsigned TMAX = 200;

  localparam logic [11:0] W = 12'd100;
  localparam logic [11:0] B = 12'd1500;
  localparam logic [11:0] M = 12'd600;

  typedef struct packed {
    logic [3:0] pins;
    logic [4:0] dc1;
    logic [4:0] dc2;
  } pat_t;

  typedef struct packed {
    pat_t       pat;
    logic [2:0] st;
    logic       nf;
    logic       nc;
    logic       to;
    logic [7:0] cnt;
  } exp_t;

  typedef struct {
    string       name;
    logic [11:0] s0, s1, s2;
    logic        st, ep;
    logic [1:0]  tf;
    exp_t        e;
  } vec_t;

  localparam pat_t P_FWD  = {4'b1010, 5'd16, 5'd20};
  localparam pat_t P_SR   = {4'b1001, 5'd20, 5'd10};
  localparam pat_t P_SL   = {4'b0110, 5'd10, 5'd24};
  localparam pat_t P_TR   = {4'b1001, 5'd18, 5'd5};
  localparam pat_t P_TU   = {4'b1001, 5'd10, 5'd28};
  localparam pat_t P_TL   = {4'b0110, 5'd3,  5'd24};
  localparam pat_t P_HALT = {4'b0000, 5'd0,  5'd0};

  localparam logic [2:0] S_IDLE = 3'd0, S_FOL = 3'd1, S_NODE = 3'd2, S_TURN = 3'd3, S_STOP = 3'd5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              end_path = 1'b0;
  logic [11:0]       s0 = '0, s1 = '0, s2 = '0;
  logic [1:0]        turn_flag = '0;
  logic              m1_a, m1_b, m2_a, m2_b;
  logic [4:0]        dc1, dc2;
  logic              node_flag, node_changed, turn_timeout;
  logic [7:0]        node_count;
  logic [2:0]        state_o;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t  sb_q[$];
  string name_q[$];
  vec_t  tbl[$];

  initial forever #5 clk = ~clk;

  line_follow_ctrl_v2 #(
    .NUM_SENSORS (NS),
    .ADC_W       (AW),
    .TURN_MIN    (TMIN),
    .TURN_MAX    (TMAX)
  ) dut (
    .clk_3125KHz  (clk),
    .rst          (rst),
    .start        (start),
    .end_path     (end_path),
    .sensors      ({s2, s1, s0}),
    .turn_flag    (turn_flag),
    .m1_a         (m1_a),
    .m1_b         (m1_b),
    .m2_a         (m2_a),
    .m2_b         (m2_b),
    .dc1          (dc1),
    .dc2          (dc2),
    .node_flag    (node_flag),
    .node_changed (node_changed),
    .node_count   (node_count),
    .turn_timeout (turn_timeout),
    .state_o      (state_o)
  );

  function automatic exp_t mk(pat_t p, logic [2:0] st, logic nf, logic nc, logic to, logic [7:0] cnt);
    exp_t e;
    e.pat = p; e.st = st; e.nf = nf; e.nc = nc; e.to = to; e.cnt = cnt;
    return e;
  endfunction

  task automatic check_out();
    exp_t  e;
    exp_t  act;
    string nm;
    act = {{m1_a, m1_b, m2_a, m2_b}, dc1, dc2, state_o, node_flag, node_changed, turn_timeout, node_count};
    n_checks++;
    if (sb_q.size() == 0) begin
      $display("FAIL scoreboard_empty: DUT output with no expected entry");
    end else begin
      e  = sb_q.pop_front();
      nm = name_q.pop_front();
      if (act !== e)
        $display("FAIL %s: got pins=%b dc=%0d/%0d st=%0d nf=%b nc=%b to=%b cnt=%0d, want pins=%b dc=%0d/%0d st=%0d nf=%b nc=%b to=%b cnt=%0d",
                 nm, act.pat.pins, act.pat.dc1, act.pat.dc2, act.st, act.nf, act.nc, act.to, act.cnt,
                 e.pat.pins, e.pat.dc1, e.pat.dc2, e.st, e.nf, e.nc, e.to, e.cnt);
      else
        n_pass++;
    end
  endtask

  task automatic step(string nm, logic [11:0] a, logic [11:0] b, logic [11:0] c,
                      logic st_i, logic ep_i, logic [1:0] tf, exp_t e);
    @(negedge clk);
    s0 = a; s1 = b; s2 = c;
    start = st_i; end_path = ep_i; turn_flag = tf;
    sb_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic do_reset(string nm);
    @(negedge clk);
    rst = 1'b1; start = 1'b0; end_path = 1'b0; turn_flag = '0;
    s0 = '0; s1 = '0; s2 = '0;
    sb_q.push_back(mk(P_HALT, S_IDLE, 1'b0, 1'b0, 1'b0, 8'd0));
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    check_out();
    rst = 1'b0;
  endtask

  task automatic add(string nm, logic [11:0] a, logic [11:0] b, logic [11:0] c,
                     logic st_i, logic ep_i, logic [1:0] tf, exp_t e);
    vec_t v;
    v.name = nm; v.s0 = a; v.s1 = b; v.s2 = c; v.st = st_i; v.ep = ep_i; v.tf = tf; v.e = e;
    tbl.push_back(v);
  endtask

  initial begin
    // Follow/steer/debounce table, ending in a confirmed node with a left turn.
    add("idle_hold",       W, B, W, 1'b0, 1'b0, 2'd0, mk(P_HALT, S_IDLE, 0, 0, 0, 0));
    add("start_fwd",       W, B, W, 1'b1, 1'b0, 2'd0, mk(P_FWD,  S_FOL,  0, 0, 0, 0));
    add("all_white_fwd",   W, W, W, 1'b0, 1'b0, 2'd0, mk(P_FWD,  S_FOL,  0, 0, 0, 0));
    add("steer_r_deadband",W, M, B, 1'b0, 1'b0, 2'd0, mk(P_SR,   S_FOL,  0, 0, 0, 0));
    add("steer_l",         B, M, W, 1'b0, 1'b0, 2'd0, mk(P_SL,   S_FOL,  0, 0, 0, 0));
    add("left_and_centre", B, B, W, 1'b0, 1'b0, 2'd0, mk(P_FWD,  S_FOL,  0, 0, 0, 0));
    add("centre_fwd",      W, B, W, 1'b0, 1'b0, 2'd0, mk(P_FWD,  S_FOL,  0, 0, 0, 0));
    for (int i = 0; i < 7; i++)
      add("debounce_7",    B, B, B, 1'b0, 1'b0, 2'd0, mk(P_FWD,  S_NODE, 1, 0, 0, 0));
    add("debounce_abort",  W, B, W, 1'b0, 1'b0, 2'd0, mk(P_FWD,  S_FOL,  0, 0, 0, 0));
    add("steer_r_pre_node",W, W, B, 1'b0, 1'b0, 2'd0, mk(P_SR,   S_FOL,  0, 0, 0, 0));
    for (int i = 0; i < 7; i++)
      add("node_hold_drive", B, B, B, 1'b0, 1'b0, 2'd0, mk(P_SR,  S_NODE, 1, 0, 0, 0));
    add("node_confirm_left",B, B, B, 1'b0, 1'b0, 2'd3, mk(P_TL,  S_TURN, 1, 0, 0, 0));

    do_reset("reset_state");
    foreach (tbl[i])
      step(tbl[i].name, tbl[i].s0, tbl[i].s1, tbl[i].s2, tbl[i].st, tbl[i].ep, tbl[i].tf, tbl[i].e);

    // Left turn: all-black ignored, reacquired line honoured only from counter TMIN.
    for (int k = 0; k < 5; k++)
      step("turn_all_black_ignored", B, B, B, 1'b0, 1'b0, 2'd1, mk(P_TL, S_TURN, 1, 0, 0, 0));
    for (int k = 5; k < int'(TMIN); k++)
      step("turn_before_min", W, B, W, 1'b0, 1'b0, 2'd1, mk(P_TL, S_TURN, 1, 0, 0, 0));
    step("turn_reacquire_exit", W, B, W, 1'b0, 1'b0, 2'd1, mk(P_FWD, S_FOL, 0, 1, 0, 1));
    step("node_changed_one_cycle", W, B, W, 1'b0, 1'b0, 2'd1, mk(P_FWD, S_FOL, 0, 0, 0, 1));

    // Right turn that never reacquires the line and times out.
    for (int i = 0; i < 7; i++)
      step("node2_debounce", B, B, B, 1'b0, 1'b0, 2'd0, mk(P_FWD, S_NODE, 1, 0, 0, 1));
    step("node2_confirm_right", B, B, B, 1'b0, 1'b0, 2'd1, mk(P_TR, S_TURN, 1, 0, 0, 1));
    for (int k = 0; k < int'(TMAX); k++)
      step("turn_wait_timeout", W, W, W, 1'b0, 1'b0, 2'd0, mk(P_TR, S_TURN, 1, 0, 0, 1));
    step("turn_timeout_exit", W, W, W, 1'b0, 1'b0, 2'd0, mk(P_FWD, S_FOL, 0, 1, 1, 2));
    step("turn_timeout_one_cycle", W, W, W, 1'b0, 1'b0, 2'd0, mk(P_FWD, S_FOL, 0, 0, 0, 2));

    // U-turn interrupted by end_path; STOP absorbs start and sensor activity.
    step("node3_centre", W, B, W, 1'b0, 1'b0, 2'd0, mk(P_FWD, S_FOL, 0, 0, 0, 2));
    for (int i = 0; i < 7; i++)
      step("node3_debounce", B, B, B, 1'b0, 1'b0, 2'd2, mk(P_FWD, S_NODE, 1, 0, 0, 2));
    step("node3_confirm_uturn", B, B, B, 1'b0, 1'b0, 2'd2, mk(P_TU, S_TURN, 1, 0, 0, 2));
    for (int k = 0; k < 3; k++)
      step("uturn_running", W, B, W, 1'b0, 1'b0, 2'd0, mk(P_TU, S_TURN, 1, 0, 0, 2));
    step("end_path_mid_turn", W, B, W, 1'b0, 1'b1, 2'd0, mk(P_HALT, S_STOP, 0, 0, 0, 2));
    for (int k = 0; k < 5; k++)
      step("stop_absorbing", W, B, W, 1'b1, 1'b0, 2'd0, mk(P_HALT, S_STOP, 0, 0, 0, 2));

    // Reset clears classes, counters and a pending debounce.
    do_reset("reset_from_stop");
    step("classes_cleared_by_reset", M, M, B, 1'b1, 1'b0, 2'd0, mk(P_SR, S_FOL, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      step("pre_reset_debounce", B, B, B, 1'b0, 1'b0, 2'd0, mk(P_SR, S_NODE, 1, 0, 0, 0));
    do_reset("reset_mid_debounce");
    step("start_and_end_path", W, B, W, 1'b1, 1'b1, 2'd0, mk(P_HALT, S_STOP, 0, 0, 0, 0));
    step("stop_ignores_start", W, B, W, 1'b1, 1'b0, 2'd0, mk(P_HALT, S_STOP, 0, 0, 0, 0));

    if (sb_q.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_leftover: %0d entries, want 0", sb_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
